gif_frame_loader: RTL and testbench
===================================

# gif_frame_loader

Consumer side of the GIF frame-sequencing interface. On each `frame_changed` pulse it takes the new `frame_actual` index and copies that frame's pixels from a multi-frame synchronous ROM into the display framebuffer's write port. It sits between the frame sequencer and the VGA framebuffer, and reports completion so the display path can swap or unblank.

## Interface

Parameters:
- `TOTAL_FRAMES`, 4: number of frames stored in the ROM. Must be ≤ 4, because the index is 2 bits.
- `FRAME_W`, 64: frame width in pixels.
- `FRAME_H`, 64: frame height in pixels.
- `PIXEL_BITS`, 12: pixel width (RGB444).
- Derived: `FRAME_PIXELS = FRAME_W*FRAME_H`; `FB_AW = clog2(FRAME_PIXELS)`; `ROM_AW = clog2(4*FRAME_PIXELS)`.

Ports:
- `clk`  in  1  single system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  block enable; low aborts any load and holds the block idle.
- `frame_actual`  in  2  requested frame index; sampled only when `frame_changed`=1.
- `frame_changed`  in  1  one-cycle request pulse from the sequencer.
- `rom_addr`  out  ROM_AW  ROM read address, registered.
- `rom_data`  in  PIXEL_BITS  ROM read data, valid the cycle after `rom_addr`.
- `fb_we`  out  1  framebuffer write enable, registered.
- `fb_addr`  out  FB_AW  framebuffer write address, registered.
- `fb_data`  out  PIXEL_BITS  equals `rom_data`, combinational passthrough.
- `busy`  out  1  high while a load is in progress.
- `load_done`  out  1  one-cycle pulse when a frame copy completes.
- `loaded_frame`  out  2  index of the last completely loaded frame.

## Operation

States: `IDLE`, `READ`, `DRAIN`.

**IDLE**
- On `enable & frame_changed & (frame_actual < TOTAL_FRAMES)`:
  - latch the index;
  - `rom_addr <= index*FRAME_PIXELS`;
  - pixel counter `<= 0`;
  - `busy <= 1`;
  - go to `READ`.
- Requests with index ≥ `TOTAL_FRAMES` are dropped.

**READ**
- Each cycle, `rom_addr` presents pixel `p` (p = 0..FRAME_PIXELS-1, incrementing by 1).
- A one-stage valid pipeline drives `fb_we <= 1` and `fb_addr <= p`, aligned with the returning `rom_data`.
- After pixel `FRAME_PIXELS-1` is issued, go to `DRAIN`.

**DRAIN**
- Performs the final write (`fb_we`=1, `fb_addr`=FRAME_PIXELS-1).
- Then `load_done <= 1`, `loaded_frame <= latched index`, `busy <= 0`.
- Go to `IDLE`, or restart if a request is pending (see below).

**Request during a load**
- A valid request arriving in `READ` or `DRAIN` is stored in a pending flag plus pending index. If several arrive, the latest wins.
- The current copy is never interrupted.
- At the end of `DRAIN`, if pending is set:
  - `load_done` still pulses for the finished frame;
  - the next cycle enters `READ` directly with the pending index;
  - `busy` stays high with no gap;
  - pending is cleared.
- A request arriving in the same cycle as the `DRAIN`→exit transition is treated as pending.

**Enable low**
- Takes effect on the next edge in any state: go to `IDLE`, `fb_we`=0, `busy`=0, pending cleared, no `load_done`.
- `loaded_frame` keeps its value; a partially written framebuffer is not reported.

**Reset**
- Takes effect in any state, including mid-load.
- Reset values: `rom_addr`=0, `fb_we`=0, `fb_addr`=0, `busy`=0, `load_done`=0, `loaded_frame`=0, pending=0, state=`IDLE`.

**Arithmetic**
- The ROM base `index*FRAME_PIXELS` is computed at `ROM_AW` width.
- Pixel counter is `FB_AW` bits; the terminal compare is against `FRAME_PIXELS-1` (no reliance on natural wrap).

## Timing

- Let the request be sampled at edge E0, and N = `FRAME_PIXELS`.
- `busy`=1 and `rom_addr`=base from E0+1.
- `rom_addr` = base+p during cycle E0+1+p.
- `fb_we`=1 during cycles E0+2 .. E0+N+1, with `fb_addr` = 0..N-1.
- `load_done`=1 and `loaded_frame` updated during cycle E0+N+2; `busy`=0 that cycle unless a pending request restarts the load.
- Load latency: N+2 cycles from request to `load_done`. Exactly N writes, with no gaps and no duplicates.
- With a pending restart, the next base address appears at cycle E0+N+2. Writes resume at E0+N+3, leaving exactly one `fb_we`-low cycle.

## Configuration

Macro `GIF_LOADER_SKIP_SAME_EN`:
- **Defined:** a request whose index equals `loaded_frame` is dropped, provided at least one load has completed since reset or enable-low. This applies both in `IDLE` and when evaluating the pending request. It saves bandwidth for static frames.
- **Undefined:** every valid request reloads, even for the same index.

## Test plan

Bench parameters: `FRAME_W`=4, `FRAME_H`=2 (N=8), `TOTAL_FRAMES`=4. ROM model returns data = address.

- **Single load:** request index 2 → `rom_addr` 16..23 in consecutive cycles; `fb_we` for 8 cycles with `fb_addr` 0..7 and `fb_data` 16..23; `load_done` at E0+10; `loaded_frame`=2.
- **Mid-load request:** requests for index 1 then index 3 during the index-0 load → `load_done` for 0; immediate reload of 3 (base 24) with one idle write cycle; index 1 never loaded.
- **Abort:** `enable` dropped at E0+4 → `fb_we`=0 and `busy`=0 the next cycle; no `load_done`; `loaded_frame` unchanged.
- **Reset mid-load:** `rst` at E0+5 → all outputs at reset values the next cycle; a new request afterwards loads normally.
- **Invalid index:** `TOTAL_FRAMES`=3 with a request for index 3 → ignored, `busy` stays 0.
- **Skip-same:** with `GIF_LOADER_SKIP_SAME_EN` defined, repeat a request for index 2 after loading 2 → no `busy`, no writes. With the macro undefined → full 8-write reload.

Source files
------------

// File: rtl/gif_frame_loader_if.sv
// rtl/gif_frame_loader_if.sv - request, ROM read and framebuffer write bus of gif_frame_loader
//
// Purpose: bundles the frame request inputs, the ROM read port and the
// framebuffer write port into one interface.
// Signals:
//   frame_actual  [1:0]           requested frame index (from sequencer)
//   frame_changed                 one-cycle request pulse (from sequencer)
//   rom_addr      [ROM_AW-1:0]    ROM read address (from loader)
//   rom_data      [PIXEL_BITS-1:0] ROM read data, one cycle after rom_addr
//   fb_we                         framebuffer write enable (from loader)
//   fb_addr       [FB_AW-1:0]     framebuffer write address (from loader)
//   fb_data       [PIXEL_BITS-1:0] framebuffer write data (from loader)
// Modports: master = loader side, slave = sequencer/ROM/framebuffer side.

interface gif_frame_loader_if #(
   parameter int FRAME_W    = 64,
   parameter int FRAME_H    = 64,
   parameter int PIXEL_BITS = 12
);
   localparam int FRAME_PIXELS = FRAME_W * FRAME_H;
   localparam int FB_AW        = $clog2(FRAME_PIXELS);
   localparam int ROM_AW       = $clog2(4 * FRAME_PIXELS);

   logic [1:0]            frame_actual;
   logic                  frame_changed;
   logic [ROM_AW-1:0]     rom_addr;
   logic [PIXEL_BITS-1:0] rom_data;
   logic                  fb_we;
   logic [FB_AW-1:0]      fb_addr;
   logic [PIXEL_BITS-1:0] fb_data;

   modport master (
      input  frame_actual, frame_changed, rom_data,
      output rom_addr, fb_we, fb_addr, fb_data
   );

   modport slave (
      output frame_actual, frame_changed, rom_data,
      input  rom_addr, fb_we, fb_addr, fb_data
   );
endinterface

// File: rtl/gif_frame_loader.sv
// rtl/gif_frame_loader.sv - copies a requested GIF frame from multi-frame ROM into the framebuffer
//
// Purpose: on a frame_changed pulse, reads FRAME_PIXELS pixels of the
// selected frame from a synchronous ROM and writes them to the framebuffer
// write port, then pulses load_done. Requests arriving mid-load are queued
// (latest wins) and start immediately after the current copy.
// Optional feature macro: GIF_LOADER_SKIP_SAME_EN (drop requests for the
// frame that is already loaded).
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   enable        block enable; low aborts any load and idles the block
//   bus           gif_frame_loader_if.master (request, ROM read, FB write)
//   busy          high while a load is in progress
//   load_done     one-cycle pulse when a frame copy completes
//   loaded_frame  index of the last completely loaded frame

module gif_frame_loader #(
   parameter int TOTAL_FRAMES = 4,
   parameter int FRAME_W      = 64,
   parameter int FRAME_H      = 64,
   parameter int PIXEL_BITS   = 12
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   gif_frame_loader_if.master  bus,
   output logic                busy,
   output logic                load_done,
   output logic [1:0]          loaded_frame
);
   localparam int FRAME_PIXELS = FRAME_W * FRAME_H;
   localparam int FB_AW        = $clog2(FRAME_PIXELS);
   localparam int ROM_AW       = $clog2(4 * FRAME_PIXELS);

   localparam logic [ROM_AW-1:0] FRAME_PIXELS_R = ROM_AW'(FRAME_PIXELS);
   localparam logic [FB_AW-1:0]  LAST_PIX       = FB_AW'(FRAME_PIXELS - 1);

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   state_t            state;
   logic [1:0]        idx;
   logic [1:0]        pend_idx;
   logic              pend;
   logic [FB_AW-1:0]  pix;

   logic              req_valid;
   logic              eff_pend;
   logic [1:0]        eff_idx;
   logic              idle_start;
   logic              restart;

   function automatic logic [ROM_AW-1:0] rom_base(input logic [1:0] i);
      return ROM_AW'(i) * FRAME_PIXELS_R;
   endfunction

   // ROM data returns aligned with the registered fb_we/fb_addr, so it goes straight through.
   assign bus.fb_data = bus.rom_data;

   assign req_valid = enable && bus.frame_changed && (32'(bus.frame_actual) < TOTAL_FRAMES);

   // Pending view at the end of DRAIN: a request in that same cycle overrides the stored one.
   always_comb begin
      eff_pend = pend;
      eff_idx  = pend_idx;
      if (req_valid) begin
         eff_pend = 1'b1;
         eff_idx  = bus.frame_actual;
      end
   end

`ifdef GIF_LOADER_SKIP_SAME_EN
   logic have_loaded;

   assign idle_start = req_valid && !(have_loaded && (bus.frame_actual == loaded_frame));
   // At DRAIN exit the frame just finished becomes loaded_frame, so compare against idx.
   assign restart    = eff_pend && (eff_idx != idx);
`else
   assign idle_start = req_valid;
   assign restart    = eff_pend;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         idx          <= '0;
         pend_idx     <= '0;
         pend         <= 1'b0;
         pix          <= '0;
         bus.rom_addr <= '0;
         bus.fb_we    <= 1'b0;
         bus.fb_addr  <= '0;
         busy         <= 1'b0;
         load_done    <= 1'b0;
         loaded_frame <= '0;
`ifdef GIF_LOADER_SKIP_SAME_EN
         have_loaded  <= 1'b0;
`endif
      end else if (!enable) begin
         state        <= IDLE;
         pend         <= 1'b0;
         bus.fb_we    <= 1'b0;
         busy         <= 1'b0;
         load_done    <= 1'b0;
`ifdef GIF_LOADER_SKIP_SAME_EN
         have_loaded  <= 1'b0;
`endif
      end else begin
         load_done <= 1'b0;
         bus.fb_we <= 1'b0;
         case (state)
            IDLE: begin
               if (idle_start) begin
                  idx          <= bus.frame_actual;
                  bus.rom_addr <= rom_base(bus.frame_actual);
                  pix          <= '0;
                  busy         <= 1'b1;
                  state        <= READ;
               end
            end
            READ: begin
               if (req_valid) begin
                  pend     <= 1'b1;
                  pend_idx <= bus.frame_actual;
               end
               // Write for the pixel whose address is on rom_addr now; data arrives next cycle.
               bus.fb_we   <= 1'b1;
               bus.fb_addr <= pix;
               if (pix == LAST_PIX) begin
                  state <= DRAIN;
               end else begin
                  pix          <= pix + 1'b1;
                  bus.rom_addr <= bus.rom_addr + 1'b1;
               end
            end
            DRAIN: begin
               // The final write is on the bus during this cycle.
               load_done    <= 1'b1;
               loaded_frame <= idx;
               pend         <= 1'b0;
`ifdef GIF_LOADER_SKIP_SAME_EN
               have_loaded  <= 1'b1;
`endif
               if (restart) begin
                  idx          <= eff_idx;
                  bus.rom_addr <= rom_base(eff_idx);
                  pix          <= '0;
                  busy         <= 1'b1;
                  state        <= READ;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_gif_frame_loader.sv
// tb/tb_gif_frame_loader.sv - scoreboard testbench for gif_frame_loader

module tb_gif_frame_loader;
   localparam int FW = 4;
   localparam int FH = 2;
   localparam int N  = FW * FH;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic enable = 1'b1;

   logic       busy, load_done;
   logic [1:0] loaded_frame;
   logic       busy3, load_done3;
   logic [1:0] loaded_frame3;

   int checks = 0;
   int errors = 0;

   int exp_addr[$];
   int exp_data[$];
   int exp_done[$];

   gif_frame_loader_if #(.FRAME_W(FW), .FRAME_H(FH), .PIXEL_BITS(12)) bus ();
   gif_frame_loader_if #(.FRAME_W(FW), .FRAME_H(FH), .PIXEL_BITS(12)) bus3 ();

   gif_frame_loader #(.TOTAL_FRAMES(4), .FRAME_W(FW), .FRAME_H(FH), .PIXEL_BITS(12)) u_dut (
      .clk(clk), .rst(rst), .enable(enable), .bus(bus),
      .busy(busy), .load_done(load_done), .loaded_frame(loaded_frame)
   );

   gif_frame_loader #(.TOTAL_FRAMES(3), .FRAME_W(FW), .FRAME_H(FH), .PIXEL_BITS(12)) u_dut3 (
      .clk(clk), .rst(rst), .enable(enable), .bus(bus3),
      .busy(busy3), .load_done(load_done3), .loaded_frame(loaded_frame3)
   );

   always #5 clk = ~clk;

   // Synchronous ROMs: data = address, one cycle latency.
   always @(posedge clk) bus.rom_data  <= 12'(bus.rom_addr);
   always @(posedge clk) bus3.rom_data <= 12'(bus3.rom_addr);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic request(input int f);
      bus.frame_actual  = 2'(f);
      bus.frame_changed = 1'b1;
      tick();
      bus.frame_changed = 1'b0;
   endtask

   task automatic push_load(input int f, input int nwrites, input bit done);
      for (int p = 0; p < nwrites; p++) begin
         exp_addr.push_back(p);
         exp_data.push_back(f * N + p);
      end
      if (done) exp_done.push_back(f);
   endtask

   task automatic wait_done(input int max_cyc);
      int n = 0;
      while (load_done !== 1'b1 && n < max_cyc) begin
         tick();
         n++;
      end
      checks++;
      if (load_done !== 1'b1) begin
         errors++;
         $display("FAIL wait_done actual=timeout required=load_done within %0d cycles", max_cyc);
      end
   endtask

   // Monitor: every framebuffer write and every load_done is checked against the queues.
   always @(negedge clk) begin
      if (bus.fb_we === 1'b1) begin
         if (exp_addr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write actual=addr %0d required=no write", bus.fb_addr);
         end else begin
            chk("fb_addr", 32'(bus.fb_addr), 32'(exp_addr.pop_front()));
            chk("fb_data", 32'(bus.fb_data), 32'(exp_data.pop_front()));
         end
      end
      if (load_done === 1'b1) begin
         if (exp_done.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=frame %0d required=no load_done", loaded_frame);
         end else begin
            chk("loaded_frame", 32'(loaded_frame), 32'(exp_done.pop_front()));
         end
      end
   end

   initial begin
      bus.frame_actual   = 2'd0;
      bus.frame_changed  = 1'b0;
      bus3.frame_actual  = 2'd0;
      bus3.frame_changed = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      chk("rst_busy", 32'(busy), 0);
      chk("rst_fb_we", 32'(bus.fb_we), 0);
      chk("rst_rom_addr", 32'(bus.rom_addr), 0);
      chk("rst_loaded_frame", 32'(loaded_frame), 0);
      tick();

      // Invalid index on the 3-frame instance, then a valid one
      bus3.frame_actual  = 2'd3;
      bus3.frame_changed = 1'b1;
      tick();
      bus3.frame_changed = 1'b0;
      chk("invalid_busy", 32'(busy3), 0);
      tick();
      tick();
      chk("invalid_busy_later", 32'(busy3), 0);
      bus3.frame_actual  = 2'd2;
      bus3.frame_changed = 1'b1;
      tick();
      bus3.frame_changed = 1'b0;
      chk("valid3_busy", 32'(busy3), 1);
      chk("valid3_rom_addr", 32'(bus3.rom_addr), 16);
      for (int i = 0; i < 12; i++) tick();

      // Single load of frame 2 with exact timing
      push_load(2, N, 1'b1);
      request(2);
      chk("single_busy", 32'(busy), 1);
      for (int p = 0; p < N; p++) begin
         chk("single_rom_addr", 32'(bus.rom_addr), 32'(16 + p));
         tick();
      end
      chk("single_done_early", 32'(load_done), 0);
      chk("single_busy_drain", 32'(busy), 1);
      tick();
      chk("single_done", 32'(load_done), 1);
      chk("single_busy_end", 32'(busy), 0);
      chk("single_loaded", 32'(loaded_frame), 2);
      tick();
      chk("single_done_pulse", 32'(load_done), 0);
      tick();

      // Mid-load requests: 1 then 3 during load of 0; only 3 follows
      push_load(0, N, 1'b1);
      push_load(3, N, 1'b1);
      request(0);
      tick();
      tick();
      request(1);
      tick();
      request(3);
      wait_done(30);
      chk("restart_gap_we", 32'(bus.fb_we), 0);
      chk("restart_busy", 32'(busy), 1);
      chk("restart_rom_addr", 32'(bus.rom_addr), 24);
      tick();
      chk("restart_we", 32'(bus.fb_we), 1);
      chk("restart_fb_addr", 32'(bus.fb_addr), 0);
      wait_done(30);
      chk("restart_loaded", 32'(loaded_frame), 3);
      tick();
      chk("restart_busy_end", 32'(busy), 0);
      tick();

      // Abort: enable sampled low at E0+4, two writes already made
      push_load(1, 2, 1'b0);
      request(1);
      tick();
      tick();
      enable = 1'b0;
      tick();
      chk("abort_we", 32'(bus.fb_we), 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_loaded", 32'(loaded_frame), 3);
      for (int i = 0; i < 10; i++) tick();
      enable = 1'b1;
      tick();

      // Reset mid-load at E0+5, then a normal load
      push_load(2, 3, 1'b0);
      request(2);
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk("rstmid_rom_addr", 32'(bus.rom_addr), 0);
      chk("rstmid_fb_we", 32'(bus.fb_we), 0);
      chk("rstmid_fb_addr", 32'(bus.fb_addr), 0);
      chk("rstmid_busy", 32'(busy), 0);
      chk("rstmid_done", 32'(load_done), 0);
      chk("rstmid_loaded", 32'(loaded_frame), 0);
      rst = 1'b0;
      tick();
      push_load(1, N, 1'b1);
      request(1);
      wait_done(30);
      chk("after_rst_loaded", 32'(loaded_frame), 1);
      tick();
      tick();

      // Same-index repeat
`ifdef GIF_LOADER_SKIP_SAME_EN
      request(1);
      chk("skip_busy", 32'(busy), 0);
      for (int i = 0; i < 12; i++) tick();
      chk("skip_busy_later", 32'(busy), 0);
`else
      push_load(1, N, 1'b1);
      request(1);
      chk("reload_busy", 32'(busy), 1);
      wait_done(30);
`endif
      for (int i = 0; i < 5; i++) tick();

      chk("writes_left", 32'(exp_addr.size()), 0);
      chk("dones_left", 32'(exp_done.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
